// File: rtl/elevator_controller.sv
// SCAN car-motion controller: consumes latched floor requests, moves one floor per
// TRAVEL_CYCLES (+1 arrive cycle), holds the door DOOR_CYCLES and clears served requests.
module elevator_controller #(
   parameter int unsigned FLOORS        = 8,
   parameter int unsigned TRAVEL_CYCLES = 16,
   parameter int unsigned DOOR_CYCLES   = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [FLOORS-1:0]         req,
   input  logic                      req_flag,
   output logic [FLOORS-1:0]         clr,
   output logic [$clog2(FLOORS)-1:0] floor,
   output logic                      dir_up,
   output logic                      moving,
   output logic                      door_open
);

   localparam int unsigned FW   = $clog2(FLOORS);
   localparam int unsigned TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
   localparam int unsigned TW   = $clog2(TMAX + 1);

   typedef enum logic [1:0] {
      IDLE,
      MOVE,
      ARRIVE,
      DOOR
   } state_t;

   state_t            state_q, state_d;
   logic [FW-1:0]     floor_q, floor_d;
   logic              dir_up_q, dir_up_d;
   logic              moving_q, moving_d;
   logic              door_open_q, door_open_d;
   logic [FLOORS-1:0] clr_q, clr_d;
   logic [TW-1:0]     timer_q, timer_d;

   logic [FLOORS-1:0] above_mask, below_mask, here_onehot;
   logic              here, any_above, any_below, ahead, behind;

   always_comb begin
      above_mask  = '0;
      below_mask  = '0;
      here_onehot = '0;
      for (int unsigned i = 0; i < FLOORS; i++) begin
         if (i > 32'(floor_q)) above_mask[i] = 1'b1;
         if (i < 32'(floor_q)) below_mask[i] = 1'b1;
         if (i == 32'(floor_q)) here_onehot[i] = 1'b1;
      end
      here      = |(req & here_onehot);
      any_above = |(req & above_mask);
      any_below = |(req & below_mask);
      ahead     = dir_up_q ? any_above : any_below;
      behind    = dir_up_q ? any_below : any_above;
   end

   always_comb begin
      state_d     = state_q;
      floor_d     = floor_q;
      dir_up_d    = dir_up_q;
      moving_d    = 1'b0;
      door_open_d = 1'b0;
      clr_d       = '0;
      timer_d     = '0;

      unique case (state_q)
         IDLE, ARRIVE: begin
            // IDLE waits for the pending flag; ARRIVE decides on req alone.
            if ((state_q == ARRIVE) || (req_flag && (req != '0))) begin
               if (here) begin
                  state_d     = DOOR;
                  door_open_d = 1'b1;
                  clr_d       = here_onehot;
               end else if (ahead) begin
                  state_d  = MOVE;
                  moving_d = 1'b1;
               end else if (behind) begin
                  state_d  = MOVE;
                  moving_d = 1'b1;
                  dir_up_d = ~dir_up_q;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         MOVE: begin
            if (timer_q == TW'(TRAVEL_CYCLES - 1)) begin
               state_d = ARRIVE;
               floor_d = dir_up_q ? floor_q + FW'(1) : floor_q - FW'(1);
            end else begin
               timer_d  = timer_q + TW'(1);
               moving_d = 1'b1;
            end
         end
         DOOR: begin
            if (timer_q == TW'(DOOR_CYCLES - 1)) begin
               state_d = IDLE;
            end else begin
               timer_d     = timer_q + TW'(1);
               door_open_d = 1'b1;
               clr_d       = here_onehot;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         floor_q     <= '0;
         dir_up_q    <= 1'b1;
         moving_q    <= 1'b0;
         door_open_q <= 1'b0;
         clr_q       <= '0;
         timer_q     <= '0;
      end else begin
         state_q     <= state_d;
         floor_q     <= floor_d;
         dir_up_q    <= dir_up_d;
         moving_q    <= moving_d;
         door_open_q <= door_open_d;
         clr_q       <= clr_d;
         timer_q     <= timer_d;
      end
   end

   assign clr       = clr_q;
   assign floor     = floor_q;
   assign dir_up    = dir_up_q;
   assign moving    = moving_q;
   assign door_open = door_open_q;

endmodule

// File: tb/tb_elevator_controller.sv
// Bench for elevator_controller: a behavioural button latch feeds req, expected stops
// are queued at stimulus time and checked when the door opens.
module tb_elevator_controller;

   localparam int unsigned FLOORS = 8;
   localparam int unsigned TRAV   = 4;
   localparam int unsigned DOORC  = 6;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] req;
   logic       req_flag;
   logic [7:0] clr;
   logic [2:0] floor;
   logic       dir_up, moving, door_open;

   typedef struct {
      logic [2:0] fl;
      logic [7:0] clr;
   } stop_t;

   stop_t sb[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   int    door_len = 0;
   logic  prev_door = 1'b0;

   assign req_flag = |req;

   elevator_controller #(
      .FLOORS        (FLOORS),
      .TRAVEL_CYCLES (TRAV),
      .DOOR_CYCLES   (DOORC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_flag  (req_flag),
      .clr       (clr),
      .floor     (floor),
      .dir_up    (dir_up),
      .moving    (moving),
      .door_open (door_open)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Button latch model plus door/scoreboard monitor.
   always @(negedge clk) begin
      stop_t e;
      req = req & ~clr;
      if (door_open && !prev_door) begin
         check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("stop_floor", 32'(floor), 32'(e.fl));
            check("stop_clr", 32'(clr), 32'(e.clr));
         end
         door_len = 0;
      end
      if (door_open) door_len++;
      if (!door_open && prev_door) begin
         check("door_len", 32'(door_len), 32'(DOORC));
         check("clr_off", 32'(clr), 32'd0);
      end
      prev_door = door_open;
   end

   task automatic wait_served(input int max_cyc);
      int n = 0;
      while ((sb.size() != 0 || door_open) && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check("served_in_time", 32'(n < max_cyc), 32'd1);
   endtask

   task automatic door_latency(input string tag, input int exp);
      int n = 0;
      while (!door_open && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(n), 32'(exp));
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      repeat (cycles) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int n;
      reset = 1'b1;
      req   = '0;
      @(negedge clk);

      // 1: reset state
      do_reset(2);
      check("rst_floor", 32'(floor), 32'd0);
      check("rst_dir_up", 32'(dir_up), 32'd1);
      check("rst_moving", 32'(moving), 32'd0);
      check("rst_door", 32'(door_open), 32'd0);
      check("rst_clr", 32'(clr), 32'd0);

      // 2: single request three floors up
      sb.push_back('{fl: 3'd3, clr: 8'h08});
      req = req | 8'h08;
      door_latency("lat_0_to_3", 1 + 3 * (TRAV + 1));
      wait_served(100);
      @(negedge clk);
      check("idle_after_door", 32'({moving, door_open}), 32'd0);

      // 3: request at current floor opens on the next edge
      do_reset(1);
      sb.push_back('{fl: 3'd0, clr: 8'h01});
      req = req | 8'h01;
      door_latency("lat_here", 1);
      check("here_not_moving", 32'(moving), 32'd0);
      wait_served(50);

      // 4: park at floor 2 going up, then ahead wins over behind
      sb.push_back('{fl: 3'd2, clr: 8'h04});
      req = req | 8'h04;
      wait_served(100);
      check("at2_dir_up", 32'(dir_up), 32'd1);
      sb.push_back('{fl: 3'd6, clr: 8'h40});
      sb.push_back('{fl: 3'd0, clr: 8'h01});
      req = req | 8'h41;
      wait_served(300);
      check("at0_dir_down", 32'(dir_up), 32'd0);
      check("at0_floor", 32'(floor), 32'd0);

      // 5: mid-travel request at 3 served before 5
      sb.push_back('{fl: 3'd3, clr: 8'h08});
      sb.push_back('{fl: 3'd5, clr: 8'h20});
      req = req | 8'h20;
      n = 0;
      while (floor != 3'd1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("reached_floor1", 32'(n < 100), 32'd1);
      req = req | 8'h08;
      wait_served(300);
      check("at5_floor", 32'(floor), 32'd5);

      // 6: reset while moving at floor 4, pending request then served from 0
      sb.push_back('{fl: 3'd0, clr: 8'h01});
      req = req | 8'h01;
      n = 0;
      while (!(floor == 3'd4 && moving) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("moving_at4", 32'(n < 100), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_floor", 32'(floor), 32'd0);
      check("midrst_moving", 32'(moving), 32'd0);
      check("midrst_clr", 32'(clr), 32'd0);
      check("midrst_dir_up", 32'(dir_up), 32'd1);
      reset = 1'b0;
      door_latency("lat_after_rst", 1);
      wait_served(50);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
